// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths, lane record and round-robin helper for the common data bus.
package cdb_pkg;

    localparam int ROBEN_W_DEF = 5;
    localparam int DATA_W_DEF  = 32;

    typedef struct packed {
        logic                   valid;
        logic [ROBEN_W_DEF-1:0] roben;
        logic [DATA_W_DEF-1:0]  data;
        logic                   exception;
    } cdb_lane_t;

    function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: round-robin scan granting up to NUM_LANES requesters, in scan order, starting at rr_ptr.
module cdb_rr_picker
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int NUM_LANES = 2,
    parameter int PTR_W     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [PTR_W-1:0]           rr_ptr,
    output logic [NUM_SRC-1:0]         grant,
    output logic [NUM_LANES*PTR_W-1:0] lane_src,
    output logic [NUM_LANES-1:0]       lane_valid,
    output logic [PTR_W-1:0]           next_ptr
);

    always_comb begin
        int cnt;
        int idx;
        grant      = '0;
        lane_src   = '0;
        lane_valid = '0;
        next_ptr   = rr_ptr;
        cnt        = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr_ptr) + i;
            idx = (idx >= NUM_SRC) ? idx - NUM_SRC : idx;
            if (req[idx] && cnt < NUM_LANES) begin
                grant[idx]                     = 1'b1;
                lane_src[cnt*PTR_W +: PTR_W]   = PTR_W'(idx);
                lane_valid[cnt]                = 1'b1;
                next_ptr                       = PTR_W'(rr_inc(idx, NUM_SRC));
                cnt                            = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrated common data bus, round-robin over NUM_SRC producers onto NUM_LANES registered lanes.
// Define CDB_STATS_EN to add broadcast/stall/exception counters.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int NUM_LANES = 2,
    parameter int ROBEN_W   = ROBEN_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*ROBEN_W-1:0]   src_roben,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    input  logic [NUM_SRC-1:0]           src_exception,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [NUM_LANES-1:0]         cdb_valid,
    output logic [NUM_LANES*ROBEN_W-1:0] cdb_roben,
    output logic [NUM_LANES*DATA_W-1:0]  cdb_data,
    output logic [NUM_LANES-1:0]         cdb_exception
`ifdef CDB_STATS_EN
   ,output logic [31:0]                  stat_broadcasts,
    output logic [31:0]                  stat_stalls,
    output logic [31:0]                  stat_exceptions
`endif
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d, next_ptr;
    logic [NUM_SRC-1:0]         zero_tag, req, grant;
    logic [NUM_LANES*PTR_W-1:0] lane_src;
    logic [NUM_LANES-1:0]       lane_valid;
    logic [NUM_LANES-1:0]       cdb_valid_q, cdb_valid_d, cdb_exception_q, cdb_exception_d;
    logic [NUM_LANES*ROBEN_W-1:0] cdb_roben_q, cdb_roben_d;
    logic [NUM_LANES*DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic                       kill;

    // Reset also gates ready so nothing is acknowledged while the block is held.
    assign kill = flush | rst;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            zero_tag[i] = (src_roben[i*ROBEN_W +: ROBEN_W] == '0);
        req = src_valid & ~zero_tag & {NUM_SRC{~kill}};
    end

    cdb_rr_picker #(.NUM_SRC(NUM_SRC), .NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .lane_src  (lane_src),
        .lane_valid(lane_valid),
        .next_ptr  (next_ptr)
    );

    assign src_ready = src_valid & (grant | zero_tag) & {NUM_SRC{~kill}};

    always_comb begin
        cdb_valid_d     = lane_valid;
        cdb_roben_d     = '0;
        cdb_data_d      = '0;
        cdb_exception_d = '0;
        rr_ptr_d        = next_ptr;
        for (int k = 0; k < NUM_LANES; k++) begin
            int sel;
            sel = int'(lane_src[k*PTR_W +: PTR_W]);
            if (lane_valid[k]) begin
                cdb_roben_d[k*ROBEN_W +: ROBEN_W] = src_roben[sel*ROBEN_W +: ROBEN_W];
                cdb_data_d[k*DATA_W +: DATA_W]    = src_data[sel*DATA_W +: DATA_W];
                cdb_exception_d[k]                = src_exception[sel];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q        <= '0;
            cdb_valid_q     <= '0;
            cdb_roben_q     <= '0;
            cdb_data_q      <= '0;
            cdb_exception_q <= '0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            cdb_valid_q     <= cdb_valid_d;
            cdb_roben_q     <= cdb_roben_d;
            cdb_data_q      <= cdb_data_d;
            cdb_exception_q <= cdb_exception_d;
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_roben     = cdb_roben_q;
    assign cdb_data      = cdb_data_q;
    assign cdb_exception = cdb_exception_q;

`ifdef CDB_STATS_EN
    logic [31:0] stat_broadcasts_q, stat_broadcasts_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;
    logic [31:0] stat_exceptions_q, stat_exceptions_d;

    // Exceptions are counted as lanes are loaded, so all three counters move on the same edge.
    always_comb begin
        stat_broadcasts_d = stat_broadcasts_q + $countones(grant);
        stat_stalls_d     = stat_stalls_q + {31'd0, (|(src_valid & ~src_ready)) & ~flush};
        stat_exceptions_d = stat_exceptions_q + $countones(cdb_valid_d & cdb_exception_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_broadcasts_q <= '0;
            stat_stalls_q     <= '0;
            stat_exceptions_q <= '0;
        end else begin
            stat_broadcasts_q <= stat_broadcasts_d;
            stat_stalls_q     <= stat_stalls_d;
            stat_exceptions_q <= stat_exceptions_d;
        end
    end

    assign stat_broadcasts = stat_broadcasts_q;
    assign stat_stalls     = stat_stalls_q;
    assign stat_exceptions = stat_exceptions_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a scan-list reference model.
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int NL = 2;
    localparam int RW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic [NS-1:0]     src_valid, src_exception, src_ready;
    logic [NS*RW-1:0]  src_roben;
    logic [NS*DW-1:0]  src_data;
    logic [NL-1:0]     cdb_valid, cdb_exception;
    logic [NL*RW-1:0]  cdb_roben;
    logic [NL*DW-1:0]  cdb_data;
`ifdef CDB_STATS_EN
    logic [31:0]       stat_broadcasts, stat_stalls, stat_exceptions;
`endif

    cdb_arbiter #(.NUM_SRC(NS), .NUM_LANES(NL), .ROBEN_W(RW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_roben    (src_roben),
        .src_data     (src_data),
        .src_exception(src_exception),
        .src_ready    (src_ready),
        .cdb_valid    (cdb_valid),
        .cdb_roben    (cdb_roben),
        .cdb_data     (cdb_data),
        .cdb_exception(cdb_exception)
`ifdef CDB_STATS_EN
       ,.stat_broadcasts(stat_broadcasts),
        .stat_stalls    (stat_stalls),
        .stat_exceptions(stat_exceptions)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic          v[NS];
    logic [RW-1:0] rob[NS];
    logic [DW-1:0] dat[NS];
    logic          ex[NS];
    logic          fl;

    int            m_ptr = 0;
    int            nxt_ptr;
    logic [NS-1:0] exp_ready;
    logic [NL-1:0] exp_v, exp_x;
    logic [NL*RW-1:0] exp_rob;
    logic [NL*DW-1:0] exp_dat;
    int unsigned   m_bc = 0, m_st = 0, m_ex = 0;
    int unsigned   snap_bc, snap_st, snap_ex;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            src_valid[i]          = v[i];
            src_roben[i*RW +: RW] = rob[i];
            src_data[i*DW +: DW]  = dat[i];
            src_exception[i]      = ex[i];
        end
        flush = fl;
    endtask

    // Reference: walk producers from the pointer, drop zero tags, hand the first NL real results to lanes.
    task automatic model();
        int g[$];
        int i;
        logic stall;
        exp_ready = '0;
        exp_v = '0; exp_x = '0; exp_rob = '0; exp_dat = '0;
        stall = 1'b0;
        if (!fl)
            for (int n = 0; n < NS; n++) begin
                i = (m_ptr + n) % NS;
                if (v[i]) begin
                    if (rob[i] == 0) exp_ready[i] = 1'b1;
                    else if (g.size() < NL) begin
                        g.push_back(i);
                        exp_ready[i] = 1'b1;
                    end
                end
            end
        nxt_ptr = (g.size() > 0) ? (g[g.size()-1] + 1) % NS : m_ptr;
        for (int k = 0; k < g.size(); k++) begin
            exp_v[k] = 1'b1;
            exp_x[k] = ex[g[k]];
            exp_rob[k*RW +: RW] = rob[g[k]];
            exp_dat[k*DW +: DW] = dat[g[k]];
        end
        for (int j = 0; j < NS; j++) if (v[j] && !exp_ready[j] && !fl) stall = 1'b1;
        m_bc += g.size();
        m_st += stall ? 1 : 0;
        m_ex += $countones(exp_v & exp_x);
    endtask

    task automatic cycle();
        drive();
        model();
        #1;
        chk("src_ready", 64'(src_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(cdb_valid), 64'(exp_v));
        chk("cdb_roben", 64'(cdb_roben), 64'(exp_rob));
        chk("cdb_data", cdb_data, exp_dat);
        chk("cdb_exception", 64'(cdb_exception), 64'(exp_x));
        m_ptr = nxt_ptr;
        @(negedge clk);
    endtask

    task automatic set_all(input logic valid);
        for (int i = 0; i < NS; i++) begin
            v[i] = valid; rob[i] = RW'(i + 1); dat[i] = $urandom; ex[i] = 1'b0;
        end
    endtask

    task automatic fresh(input int i);
        v[i]   = ($urandom_range(0, 9) < 6);
        rob[i] = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom_range(1, 31));
        dat[i] = $urandom;
        ex[i]  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst = 1'b1; fl = 1'b0;
        set_all(1'b1);
        drive();
        #12;
        chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("reset_src_ready", 64'(src_ready), 64'd0);
        chk("reset_cdb_roben", 64'(cdb_roben), 64'd0);
        chk("reset_cdb_data", cdb_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
`ifdef CDB_STATS_EN
        snap_bc = stat_broadcasts; snap_st = stat_stalls; snap_ex = stat_exceptions;
`endif
        repeat (4) begin
            for (int i = 0; i < NS; i++) dat[i] = $urandom;
            cycle();
        end
`ifdef CDB_STATS_EN
        chk("stat_bc_case2", 64'(stat_broadcasts - snap_bc), 64'd8);
        chk("stat_st_case2", 64'(stat_stalls - snap_st), 64'd4);
        chk("stat_ex_case2", 64'(stat_exceptions - snap_ex), 64'd0);
`endif
        set_all(1'b0);
        v[3] = 1'b1; rob[3] = 5'd7; dat[3] = 32'hDEADBEEF; ex[3] = 1'b1;
        cycle();
        set_all(1'b0);
        v[1] = 1'b1; rob[1] = 5'd0; v[2] = 1'b1; rob[2] = 5'd9;
        cycle();
        set_all(1'b1);
        cycle();
        set_all(1'b0);
        v[0] = 1'b1; v[2] = 1'b1; fl = 1'b1;
        cycle();
        fl = 1'b0;
        set_all(1'b1);
        cycle();
        for (int i = 0; i < NS; i++) fresh(i);
        repeat (300) begin
            fl = ($urandom_range(0, 7) == 0);
            cycle();
            for (int i = 0; i < NS; i++) if (!v[i] || exp_ready[i]) fresh(i);
        end
        fl = 1'b0;
        set_all(1'b0);
        cycle();
`ifdef CDB_STATS_EN
        chk("stat_broadcasts", 64'(stat_broadcasts), 64'(m_bc));
        chk("stat_stalls", 64'(stat_stalls), 64'(m_st));
        chk("stat_exceptions", 64'(stat_exceptions), 64'(m_ex));
`endif
        set_all(1'b1);
        ex[1] = 1'b1;
        drive();
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 64'(cdb_valid), 64'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("midreset_cdb_data", cdb_data, 64'd0);
        chk("midreset_src_ready", 64'(src_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_bc = 0; m_st = 0; m_ex = 0;
        cycle();
        cycle();
`ifdef CDB_STATS_EN
        chk("stat_bc_after_reset", 64'(stat_broadcasts), 64'(m_bc));
        chk("stat_ex_after_reset", 64'(stat_exceptions), 64'(m_ex));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
